fifo_stream_drain: RTL

//  Read-side stage sitting directly downstream of the synchronous FIFO.

---
 rtl/fifo_stream_drain.sv | 92 +++++++++
 1 files changed

// File: rtl/fifo_stream_drain.sv
// ---------------------------------------------------------------------------
// fifo_stream_drain
//   Read-side stage placed directly after a synchronous FIFO. It pops the FIFO
//   through rd_en/empty and turns the FIFO's one-cycle-latency read data into a
//   valid/ready stream. A 2-entry skid buffer keeps full throughput under
//   back-pressure. A pop is never issued while the FIFO is empty.
//
// Parameters
//   FIFO_WIDTH  data width, equal to the FIFO data_out width
//   CNT_WIDTH   width of pop_count
//
// Ports
//   clk            in   single clock, all state on posedge
//   rst_n          in   asynchronous active-low reset
//   fifo_empty     in   FIFO empty flag
//   fifo_data_out  in   FIFO read data, valid the cycle after an accepted pop
//   fifo_rd_en     out  pop request to the FIFO (combinational)
//   m_valid        out  stream data valid (registered)
//   m_ready        in   stream consumer ready
//   m_data         out  stream data, head of the skid buffer (registered)
//   pop_count      out  accepted pops, wraps modulo 2^CNT_WIDTH
// ---------------------------------------------------------------------------
module fifo_stream_drain #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  pop_count
);

    logic [1:0]            occ;        // buffered words, 0..2
    logic                  in_flight;  // pop issued last cycle, data arrives now
    logic [FIFO_WIDTH-1:0] entry0;     // head, drives m_data
    logic [FIFO_WIDTH-1:0] entry1;     // skid slot

    logic       drain;
    logic [1:0] occ_left;   // occupancy after this cycle's drain
    logic [2:0] committed;  // buffer slots already spoken for after drain
    logic [1:0] occ_nxt;

    assign drain     = m_valid & m_ready;
    assign occ_left  = occ - {1'b0, drain};
    assign committed = {1'b0, occ_left} + {2'b0, in_flight};
    assign occ_nxt   = occ_left + {1'b0, in_flight};

    // A new pop is only allowed while a slot is still free after counting the
    // word in flight, so the buffer can never overflow even if the consumer
    // stalls forever.
    assign fifo_rd_en = rst_n & ~fifo_empty & (committed < 3'd2);

    assign m_data = entry0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ       <= 2'd0;
            in_flight <= 1'b0;
            entry0    <= '0;
            entry1    <= '0;
            m_valid   <= 1'b0;
            pop_count <= '0;
        end else begin
            in_flight <= fifo_rd_en;
            if (fifo_rd_en)
                pop_count <= pop_count + 1'b1;

            // Skid word moves up to the head when the head is consumed.
            if (drain && (occ == 2'd2))
                entry0 <= entry1;

            // Arriving word goes to the first slot that is free after the drain;
            // this overrides the shift above only in the occ_left==0 case, where
            // no shift happens anyway.
            if (in_flight) begin
                if (occ_left == 2'd0)
                    entry0 <= fifo_data_out;
                else
                    entry1 <= fifo_data_out;
            end

            occ     <= occ_nxt;
            m_valid <= (occ_nxt != 2'd0);
        end
    end

endmodule
